// File: rtl/fft_pkg.sv
// Shared FFT datapath defaults, FSM encoding and saturation limit helpers
// used by the FFT core, the rounding stage and the output denormaliser.
package fft_pkg;

   localparam int FFT_IN_W   = 14;
   localparam int FFT_OUT_W  = 16;
   localparam int FFT_EXP_W  = 4;
   localparam int FFT_N_LOG2 = 10;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   function automatic longint sat_max(int w);
      return (longint'(1) << (w - 1)) - 1;
   endfunction

   function automatic longint sat_min(int w);
      return -(longint'(1) << (w - 1));
   endfunction

endpackage

// File: rtl/fft_sat_shl.sv
// One-component sign-extend, exact left shift and saturate to OUT_W bits.
// The sat flag marks a clipped result.
module fft_sat_shl
   import fft_pkg::*;
#(
   parameter int IN_W  = FFT_IN_W,
   parameter int OUT_W = FFT_OUT_W,
   parameter int EXP_W = FFT_EXP_W
) (
   input  logic [IN_W-1:0]  din,
   input  logic [EXP_W-1:0] shamt,
   output logic [OUT_W-1:0] dout,
   output logic             sat
);

   // Wide enough that the largest shift never loses a bit before clipping.
   localparam int EXT_W = IN_W + 2**EXP_W - 1;
   localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(sat_max(OUT_W));
   localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(sat_min(OUT_W));
   localparam logic [OUT_W-1:0] MAX_O = OUT_W'(sat_max(OUT_W));
   localparam logic [OUT_W-1:0] MIN_O = OUT_W'(sat_min(OUT_W));

   logic signed [EXT_W-1:0] ext;
   logic signed [EXT_W-1:0] shifted;

   always_comb begin
      ext     = EXT_W'($signed(din));
      shifted = ext <<< shamt;
      sat     = 1'b0;
      dout    = shifted[OUT_W-1:0];
      if (shifted > MAX_V) begin
         dout = MAX_O;
         sat  = 1'b1;
      end else if (shifted < MIN_V) begin
         dout = MIN_O;
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/fft_bfp_denorm.sv
// Block-floating-point denormaliser: one exponent per frame, scales 2^N_LOG2
// complex samples with saturation. FFT_DENORM_SAT_CNT_EN adds sat_cnt.
module fft_bfp_denorm
   import fft_pkg::*;
#(
   parameter int IN_W   = FFT_IN_W,
   parameter int OUT_W  = FFT_OUT_W,
   parameter int EXP_W  = FFT_EXP_W,
   parameter int N_LOG2 = FFT_N_LOG2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             exp_valid,
   output logic             exp_ready,
   input  logic [EXP_W-1:0] exp_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_re,
   input  logic [IN_W-1:0]  in_im,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_re,
   output logic [OUT_W-1:0] out_im,
   output logic             out_last,
   output logic             busy
`ifdef FFT_DENORM_SAT_CNT_EN
   ,
   output logic [15:0]      sat_cnt
`endif
);

   state_t            state;
   state_t            state_nxt;
   logic [N_LOG2-1:0] count;
   logic [EXP_W-1:0]  exp_q;
   logic [OUT_W-1:0]  sh_re;
   logic [OUT_W-1:0]  sh_im;
   logic              sat_re;
   logic              sat_im;
   logic              in_acc;
   logic              exp_acc;

   fft_sat_shl #(.IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W)) u_shl_re (
      .din   (in_re),
      .shamt (exp_q),
      .dout  (sh_re),
      .sat   (sat_re)
   );

   fft_sat_shl #(.IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W)) u_shl_im (
      .din   (in_im),
      .shamt (exp_q),
      .dout  (sh_im),
      .sat   (sat_im)
   );

   // Handshakes and frame sequencing; the output register frees a slot when it drains.
   always_comb begin
      state_nxt = state;
      exp_ready = 1'b0;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            exp_ready = 1'b1;
            if (exp_valid) state_nxt = STREAM;
         end
         STREAM: begin
            in_ready = !out_valid || out_ready;
            if (in_valid && (!out_valid || out_ready) && (count == '1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign exp_acc = exp_valid && exp_ready;
   assign in_acc  = in_valid && in_ready;
   assign busy    = (state == STREAM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         exp_q <= '0;
      end else if (exp_acc) begin
         count <= '0;
         exp_q <= exp_in;
      end else if (in_acc) begin
         count <= count + 1'b1;
      end
   end

   // Single-entry output register: reload on accept, drop valid only on a bare drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_last  <= 1'b0;
      end else if (in_acc) begin
         out_valid <= 1'b1;
         out_re    <= sh_re;
         out_im    <= sh_im;
         out_last  <= (count == '1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef FFT_DENORM_SAT_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                              sat_cnt <= '0;
      else if (exp_acc)                                     sat_cnt <= '0;
      else if (in_acc && (sat_re || sat_im) && (sat_cnt != 16'hFFFF)) sat_cnt <= sat_cnt + 16'd1;
   end
`else
   logic sat_unused;
   assign sat_unused = sat_re | sat_im;
`endif

endmodule

// File: tb/tb_fft_bfp_denorm.sv
// Self-checking bench for fft_bfp_denorm (N_LOG2=3): table vectors plus randomized
// frames against a multiply-and-clamp reference model with a scoreboard.
module tb_fft_bfp_denorm;

   localparam int IN_W   = 14;
   localparam int OUT_W  = 16;
   localparam int EXP_W  = 4;
   localparam int N_LOG2 = 3;
   localparam int FRAME  = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             exp_valid;
   logic             exp_ready;
   logic [EXP_W-1:0] exp_in;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_re;
   logic [IN_W-1:0]  in_im;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_re;
   logic [OUT_W-1:0] out_im;
   logic             out_last;
   logic             busy;
`ifdef FFT_DENORM_SAT_CNT_EN
   logic [15:0]      sat_cnt;
`endif

   always #5 clk = ~clk;

   fft_bfp_denorm #(.IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W), .N_LOG2(N_LOG2)) dut (
      .clk       (clk),
      .rst       (rst),
      .exp_valid (exp_valid),
      .exp_ready (exp_ready),
      .exp_in    (exp_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_last  (out_last),
      .busy      (busy)
`ifdef FFT_DENORM_SAT_CNT_EN
      ,
      .sat_cnt   (sat_cnt)
`endif
   );

   typedef struct {
      int e;
      int re;
      int im;
      int xre;
      int xim;
   } vec_t;

   typedef struct {
      int re;
      int im;
      int last;
   } item_t;

   vec_t  vecs[8];
   item_t sb[$];

   int nChecks = 0;
   int nErrors = 0;
   int mExp = 0;
   int mCnt = 0;
   int mSat = 0;
   int mTotal = 0;
   bit mOpen = 0;
   bit holdV = 0;
   int holdRe, holdIm, holdLast;

   // Reference: exact product with a power of two, then clamp to the output range.
   function automatic int refScale(int v, int e, output bit s);
      longint p;
      longint maxv;
      longint minv;
      maxv = (longint'(1) << (OUT_W - 1)) - 1;
      minv = -(longint'(1) << (OUT_W - 1));
      p = longint'(v) * (longint'(1) << e);
      s = 1'b0;
      if (p > maxv) begin s = 1'b1; return int'(maxv); end
      if (p < minv) begin s = 1'b1; return int'(minv); end
      return int'(p);
   endfunction

   task automatic checkOutput(string name, longint act, longint exp);
      nChecks++;
      if (act != exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: check observable state, update the model from handshakes.
   task automatic applyStimulus();
      item_t it;
      bit    sr, si;
      #1;
      checkOutput("busy", busy, mOpen);
      checkOutput("exp_ready", exp_ready, !mOpen);
      checkOutput("in_ready", in_ready, mOpen && (sb.size() == 0 || out_ready));
      checkOutput("out_valid", out_valid, sb.size() != 0);
`ifdef FFT_DENORM_SAT_CNT_EN
      checkOutput("sat_cnt", sat_cnt, mSat);
`endif
      if (holdV) begin
         checkOutput("hold_re", int'($signed(out_re)), holdRe);
         checkOutput("hold_im", int'($signed(out_im)), holdIm);
         checkOutput("hold_last", out_last, holdLast);
      end
      holdV    = out_valid && !out_ready;
      holdRe   = int'($signed(out_re));
      holdIm   = int'($signed(out_im));
      holdLast = int'(out_last);
      if (out_valid && out_ready && sb.size() != 0) begin
         it = sb.pop_front();
         checkOutput("out_re", int'($signed(out_re)), it.re);
         checkOutput("out_im", int'($signed(out_im)), it.im);
         checkOutput("out_last", out_last, it.last);
      end
      if (exp_valid && exp_ready) begin
         mExp  = int'(exp_in);
         mOpen = 1;
         mCnt  = 0;
         mSat  = 0;
      end
      if (in_valid && in_ready) begin
         it.re   = refScale(int'($signed(in_re)), mExp, sr);
         it.im   = refScale(int'($signed(in_im)), mExp, si);
         it.last = (mCnt == FRAME - 1);
         sb.push_back(it);
         if ((sr || si) && mSat < 65535) mSat++;
         mTotal++;
         mCnt++;
         if (mCnt == FRAME) begin
            mOpen = 0;
            mCnt  = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic randomData();
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) begin
         in_re = 14'h1FFF;
         in_im = 14'h2000;
      end else begin
         in_re = IN_W'($urandom_range(0, 16383));
         in_im = IN_W'($urandom_range(0, 16383));
      end
   endtask

   task automatic sendExp(int e);
      int cyc;
      exp_valid = 1'b1;
      exp_in    = EXP_W'(e);
      cyc = 0;
      while (!mOpen && cyc < 50) begin
         applyStimulus();
         cyc++;
      end
      if (!mOpen) checkOutput("exp_timeout", 0, 1);
      exp_valid = 1'b0;
   endtask

   // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready and valid.
   task automatic feedFrame(int n, int mode);
      int start;
      int last;
      int cyc;
      start = mTotal;
      last  = -1;
      cyc   = 0;
      while (((mTotal - start) < n || sb.size() != 0) && cyc < 400) begin
         if (mTotal != last) begin
            randomData();
            last = mTotal;
         end
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if ((mTotal - start) >= n)       in_valid = 1'b0;
         else if (mode == 2 && !in_valid) in_valid = 1'($urandom_range(0, 1));
         else                             in_valid = 1'b1;
         applyStimulus();
         cyc++;
      end
      if (cyc >= 400) checkOutput("frame_timeout", 0, 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      int start;
      int cyc;

      vecs[0] = '{0, -8192, 8191, -8192, 8191};
      vecs[1] = '{2, 100, -3, 400, -12};
      vecs[2] = '{2, -1, 1, -4, 4};
      vecs[3] = '{3, 8191, -8192, 32767, -32768};
      vecs[4] = '{2, 8191, -8192, 32764, -32768};
      vecs[5] = '{3, 4096, -4096, 32767, -32768};
      vecs[6] = '{15, 1, -1, 32767, -32768};
      vecs[7] = '{1, 8191, -8192, 16382, -16384};

      rst = 1'b1;
      exp_valid = 1'b0;
      exp_in = '0;
      in_valid = 1'b0;
      in_re = '0;
      in_im = '0;
      out_ready = 1'b1;
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_re", out_re, 0);
      checkOutput("rst_out_im", out_im, 0);
      checkOutput("rst_out_last", out_last, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_exp_ready", exp_ready, 1);
      checkOutput("rst_in_ready", in_ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] table vectors");
      for (int i = 0; i < 8; i++) begin
         sendExp(vecs[i].e);
         in_valid  = 1'b1;
         in_re     = IN_W'(vecs[i].re);
         in_im     = IN_W'(vecs[i].im);
         out_ready = 1'b0;
         applyStimulus();
         in_valid  = 1'b0;
         #1;
         checkOutput("tab_valid", out_valid, 1);
         checkOutput("tab_re", int'($signed(out_re)), vecs[i].xre);
         checkOutput("tab_im", int'($signed(out_im)), vecs[i].xim);
         feedFrame(FRAME - 1, 0);
      end

      $display("[TB] ready toggling frame");
      sendExp(1);
      feedFrame(FRAME, 1);

      $display("[TB] exponent offered during frame, idle hold");
      sendExp(4);
      exp_valid = 1'b1;
      exp_in    = 4'd7;
      feedFrame(FRAME, 2);
      cyc = 0;
      while (!mOpen && cyc < 20) begin
         applyStimulus();
         cyc++;
      end
      checkOutput("second_exp_taken", mOpen, 1);
      exp_valid = 1'b0;
      feedFrame(FRAME, 0);
      in_valid = 1'b1;
      randomData();
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("idle_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;

      $display("[TB] mid-frame reset");
      sendExp(2);
      start = mTotal;
      cyc   = 0;
      in_valid = 1'b1;
      while ((mTotal - start) < 3 && cyc < 50) begin
         randomData();
         applyStimulus();
         cyc++;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_out_valid", out_valid, 0);
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_exp_ready", exp_ready, 1);
      checkOutput("mid_rst_in_ready", in_ready, 0);
      sb.delete();
      mOpen = 0;
      mCnt  = 0;
      mSat  = 0;
      holdV = 0;
      @(negedge clk);
      rst = 1'b0;
      sendExp(1);
      feedFrame(FRAME, 2);

      $display("[TB] random frames");
      for (int f = 0; f < 6; f++) begin
         sendExp($urandom_range(0, 15));
         feedFrame(FRAME, 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
